// File: rtl/mips_top.sv
// Single-cycle MIPS-subset core running a fixed Fibonacci program.
// R17 is shown on five 7-segment digits. Decimal by default; define SEG_HEX_EN for hex digits.

module mips_register (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  raddr1_i,
    input  logic [4:0]  raddr2_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic        we_i,
    output logic [31:0] rdata1_o,
    output logic [31:0] rdata2_o,
    output logic [31:0] disp_o
);
    logic [31:0] RegData [0:31];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) RegData[i] <= '0;
        end else if (we_i && waddr_i != 5'd0) begin
            RegData[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == 5'd0) ? 32'd0 : RegData[raddr1_i];
    assign rdata2_o = (raddr2_i == 5'd0) ? 32'd0 : RegData[raddr2_i];
    // Display tap on $s1
    assign disp_o   = RegData[17];
endmodule

module mips_data_memory (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  addr_i,
    input  logic [31:0] wdata_i,
    input  logic        we_i,
    input  logic        re_i,
    output logic [31:0] rdata_o
);
    logic [7:0] Dmem [0:31];
    logic [4:0] base;

    assign base = {addr_i[4:2], 2'b00};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) Dmem[i] <= '0;
        end else if (we_i) begin
            Dmem[base]             <= wdata_i[7:0];
            Dmem[base | 5'd1]      <= wdata_i[15:8];
            Dmem[base | 5'd2]      <= wdata_i[23:16];
            Dmem[base | 5'd3]      <= wdata_i[31:24];
        end
    end

    assign rdata_o = re_i ? {Dmem[base | 5'd3], Dmem[base | 5'd2], Dmem[base | 5'd1], Dmem[base]}
                          : 32'd0;
endmodule

module mips_top (
    input  logic       clk,
    input  logic       rst,
    output logic [6:0] seg_first,
    output logic [6:0] seg_second,
    output logic [6:0] seg_third,
    output logic [6:0] seg_fourth,
    output logic [6:0] seg_fifth
);
    logic [31:0] pc_q, pc_d, pc_in, pc_plus4;
    logic [31:0] im_instruction, rom_data;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, waddr;
    logic [31:0] imm_ext, branch_target, jump_target;
    logic [31:0] alu_result, alu_b, r_read1, r_read2, r_wbdata, mem_rdata, disp_val;
    logic        alu_zero, r_func_ok;
    logic        c_RegDst, c_ALUSrc, c_MemtoReg, c_RegWrite, c_MemRead, c_MemWrite;
    logic        c_Branch, c_Jump;
    logic [1:0]  c_ALUOp;
    logic [3:0]  c_ALUcontrol;
    logic [3:0]  digits [0:4];

    function automatic logic [31:0] rom_word(input logic [5:0] idx);
        case (idx)
            6'd0:    rom_word = 32'h2010000A;
            6'd1:    rom_word = 32'h20080000;
            6'd2:    rom_word = 32'h20090001;
            6'd3:    rom_word = 32'h200A0000;
            6'd4:    rom_word = 32'h11500005;
            6'd5:    rom_word = 32'h01095820;
            6'd6:    rom_word = 32'h01204020;
            6'd7:    rom_word = 32'h01604820;
            6'd8:    rom_word = 32'h214A0001;
            6'd9:    rom_word = 32'h08000004;
            6'd10:   rom_word = 32'h01008820;
            6'd11:   rom_word = 32'hAC110000;
            6'd12:   rom_word = 32'h8C120000;
            6'd13:   rom_word = 32'h0800000D;
            default: rom_word = 32'h00000000;
        endcase
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0:    seg7 = 7'b1000000;
            4'h1:    seg7 = 7'b1111001;
            4'h2:    seg7 = 7'b0100100;
            4'h3:    seg7 = 7'b0110000;
            4'h4:    seg7 = 7'b0011001;
            4'h5:    seg7 = 7'b0010010;
            4'h6:    seg7 = 7'b0000010;
            4'h7:    seg7 = 7'b1111000;
            4'h8:    seg7 = 7'b0000000;
            4'h9:    seg7 = 7'b0010000;
            4'hA:    seg7 = 7'b0001000;
            4'hB:    seg7 = 7'b0000011;
            4'hC:    seg7 = 7'b1000110;
            4'hD:    seg7 = 7'b0100001;
            4'hE:    seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    assign pc_in          = pc_q;
    assign rom_data       = rom_word(pc_in[7:2]);
    assign im_instruction = rom_data;

    assign opcode  = im_instruction[31:26];
    assign rs      = im_instruction[25:21];
    assign rt      = im_instruction[20:16];
    assign rd      = im_instruction[15:11];
    assign funct   = im_instruction[5:0];
    assign imm_ext = {{16{im_instruction[15]}}, im_instruction[15:0]};

    assign r_func_ok = (funct == 6'h20) || (funct == 6'h22) || (funct == 6'h24) ||
                       (funct == 6'h25) || (funct == 6'h2A);

    // Anything not decoded leaves every enable low, so it behaves as a NOP
    always_comb begin
        c_RegDst   = 1'b0;
        c_ALUSrc   = 1'b0;
        c_MemtoReg = 1'b0;
        c_RegWrite = 1'b0;
        c_MemRead  = 1'b0;
        c_MemWrite = 1'b0;
        c_Branch   = 1'b0;
        c_Jump     = 1'b0;
        c_ALUOp    = 2'b00;
        case (opcode)
            6'h00: begin
                c_ALUOp    = 2'b10;
                c_RegDst   = r_func_ok;
                c_RegWrite = r_func_ok;
            end
            6'h08: begin
                c_ALUSrc   = 1'b1;
                c_RegWrite = 1'b1;
            end
            6'h23: begin
                c_ALUSrc   = 1'b1;
                c_MemtoReg = 1'b1;
                c_MemRead  = 1'b1;
                c_RegWrite = 1'b1;
            end
            6'h2B: begin
                c_ALUSrc   = 1'b1;
                c_MemWrite = 1'b1;
            end
            6'h04: begin
                c_ALUOp  = 2'b01;
                c_Branch = 1'b1;
            end
            6'h02:   c_Jump = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        c_ALUcontrol = 4'b0010;
        case (c_ALUOp)
            2'b01: c_ALUcontrol = 4'b0110;
            2'b10: begin
                case (funct)
                    6'h22:   c_ALUcontrol = 4'b0110;
                    6'h24:   c_ALUcontrol = 4'b0000;
                    6'h25:   c_ALUcontrol = 4'b0001;
                    6'h2A:   c_ALUcontrol = 4'b0111;
                    default: c_ALUcontrol = 4'b0010;
                endcase
            end
            default: c_ALUcontrol = 4'b0010;
        endcase
    end

    assign alu_b = c_ALUSrc ? imm_ext : r_read2;

    always_comb begin
        case (c_ALUcontrol)
            4'b0010: alu_result = r_read1 + alu_b;
            4'b0110: alu_result = r_read1 - alu_b;
            4'b0000: alu_result = r_read1 & alu_b;
            4'b0001: alu_result = r_read1 | alu_b;
            4'b0111: alu_result = {31'd0, $signed(r_read1) < $signed(alu_b)};
            default: alu_result = 32'd0;
        endcase
    end

    assign alu_zero = (alu_result == 32'd0);
    assign waddr    = c_RegDst ? rd : rt;
    assign r_wbdata = c_MemtoReg ? mem_rdata : alu_result;

    mips_register u_Register (
        .clk_i    (clk),
        .rst_i    (rst),
        .raddr1_i (rs),
        .raddr2_i (rt),
        .waddr_i  (waddr),
        .wdata_i  (r_wbdata),
        .we_i     (c_RegWrite),
        .rdata1_o (r_read1),
        .rdata2_o (r_read2),
        .disp_o   (disp_val)
    );

    mips_data_memory u_Data_memory (
        .clk_i   (clk),
        .rst_i   (rst),
        .addr_i  (alu_result[4:0]),
        .wdata_i (r_read2),
        .we_i    (c_MemWrite),
        .re_i    (c_MemRead),
        .rdata_o (mem_rdata)
    );

    assign pc_plus4      = pc_q + 32'd4;
    assign branch_target = pc_plus4 + {imm_ext[29:0], 2'b00};
    assign jump_target   = {pc_plus4[31:28], im_instruction[25:0], 2'b00};

    always_comb begin
        pc_d = pc_plus4;
        if (c_Jump)                    pc_d = jump_target;
        else if (c_Branch && alu_zero) pc_d = branch_target;
    end

    always_ff @(posedge clk) begin
        if (rst) pc_q <= 32'd0;
        else     pc_q <= pc_d;
    end

`ifdef SEG_HEX_EN
    logic seg_unused;
    assign seg_unused = ^disp_val[31:20];

    always_comb begin
        for (int i = 0; i < 5; i++) digits[i] = disp_val[4*i +: 4];
    end
`else
    logic [31:0] dec_v;

    always_comb begin
        dec_v = disp_val % 32'd100000;
        for (int i = 0; i < 5; i++) begin
            digits[i] = 4'(dec_v % 32'd10);
            dec_v     = dec_v / 32'd10;
        end
    end
`endif

    always_comb begin
        seg_first  = seg7(digits[0]);
        seg_second = seg7(digits[1]);
        seg_third  = seg7(digits[2]);
        seg_fourth = seg7(digits[3]);
        seg_fifth  = seg7(digits[4]);
    end
endmodule

// File: tb/tb_mips_top.sv
// Directed bench for mips_top: program run, PC trace, forced instruction vectors and reset rerun.
module tb_mips_top;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] seg_first, seg_second, seg_third, seg_fourth, seg_fifth;
    logic [31:0] forced_instr;
    logic [31:0] pc_exp;
    logic [31:0] trace [$];
    int total = 0;
    int bad   = 0;

    localparam int KReg  = 0;
    localparam int KMem  = 1;
    localparam int KNone = 2;
    localparam int PSeq  = 0;
    localparam int PBr   = 1;
    localparam int PJmp  = 2;

    typedef struct {
        string       name;
        logic [31:0] instr;
        int          kind;
        int          idx;
        logic [31:0] exp;
        int          pc_mode;
        logic [31:0] pc_arg;
    } vec_t;

    vec_t vecs [0:16];

    mips_top dut (
        .clk        (clk),
        .rst        (rst),
        .seg_first  (seg_first),
        .seg_second (seg_second),
        .seg_third  (seg_third),
        .seg_fourth (seg_fourth),
        .seg_fifth  (seg_fifth)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] reg_rd(input int i);
        return dut.u_Register.RegData[i];
    endfunction

    function automatic logic [31:0] mem_word(input int a);
        return {dut.u_Data_memory.Dmem[a+3], dut.u_Data_memory.Dmem[a+2],
                dut.u_Data_memory.Dmem[a+1], dut.u_Data_memory.Dmem[a]};
    endfunction

    task automatic chk_segs(input string name, input logic [6:0] e1, input logic [6:0] e2,
                            input logic [6:0] e3, input logic [6:0] e4, input logic [6:0] e5);
        chk({name, ".seg_first"},  {25'd0, seg_first},  {25'd0, e1});
        chk({name, ".seg_second"}, {25'd0, seg_second}, {25'd0, e2});
        chk({name, ".seg_third"},  {25'd0, seg_third},  {25'd0, e3});
        chk({name, ".seg_fourth"}, {25'd0, seg_fourth}, {25'd0, e4});
        chk({name, ".seg_fifth"},  {25'd0, seg_fifth},  {25'd0, e5});
    endtask

    initial begin
        // After the program: t0=55 t1=89 t2=10 t3=89 s0=10 s1=55 s2=55
        vecs[0]  = '{"add",        32'h01096020, KReg,  12, 32'd144,       PSeq, 32'd0};
        vecs[1]  = '{"sub_neg",    32'h01096822, KReg,  13, 32'hFFFFFFDE,  PSeq, 32'd0};
        vecs[2]  = '{"and",        32'h01097024, KReg,  14, 32'h11,        PSeq, 32'd0};
        vecs[3]  = '{"or",         32'h01097825, KReg,  15, 32'h7F,        PSeq, 32'd0};
        vecs[4]  = '{"slt_signed", 32'h01A8982A, KReg,  19, 32'd1,         PSeq, 32'd0};
        vecs[5]  = '{"slt_false",  32'h010AA02A, KReg,  20, 32'd0,         PSeq, 32'd0};
        vecs[6]  = '{"addi_sext",  32'h2015FFFF, KReg,  21, 32'hFFFFFFFF,  PSeq, 32'd0};
        vecs[7]  = '{"addi_r0",    32'h20000005, KReg,  0,  32'd0,         PSeq, 32'd0};
        vecs[8]  = '{"add_r0",     32'h01090020, KReg,  0,  32'd0,         PSeq, 32'd0};
        vecs[9]  = '{"sw4",        32'hAC090004, KMem,  4,  32'h59,        PSeq, 32'd0};
        vecs[10] = '{"lw4",        32'h8C160004, KReg,  22, 32'h59,        PSeq, 32'd0};
        vecs[11] = '{"lw_wrap",    32'h8C170024, KReg,  23, 32'h59,        PSeq, 32'd0};
        vecs[12] = '{"undef_op",   32'hFC000000, KReg,  17, 32'h37,        PSeq, 32'd0};
        vecs[13] = '{"nop_zero",   32'h00000000, KReg,  16, 32'h0A,        PSeq, 32'd0};
        vecs[14] = '{"beq_nt",     32'h11090003, KNone, 0,  32'd0,         PSeq, 32'd0};
        vecs[15] = '{"beq_t",      32'h11110003, KNone, 0,  32'd0,         PBr,  32'd12};
        vecs[16] = '{"j",          32'h08000040, KNone, 0,  32'd0,         PJmp, 32'h100};

        trace.push_back(32'h00);
        trace.push_back(32'h04);
        trace.push_back(32'h08);
        trace.push_back(32'h0C);
        for (int it = 0; it < 10; it++) begin
            for (int a = 32'h10; a <= 32'h24; a += 4) trace.push_back(a);
        end
        trace.push_back(32'h10);
        trace.push_back(32'h28);
        trace.push_back(32'h2C);
        trace.push_back(32'h30);
        trace.push_back(32'h34);

        // Reset state
        rst = 1'b1;
        tick(2);
        chk("reset.pc", dut.pc_in, 32'd0);
        chk("reset.r17", reg_rd(17), 32'd0);
        chk_segs("reset", 7'h40, 7'h40, 7'h40, 7'h40, 7'h40);

        // Program run with per-cycle PC trace
        rst = 1'b0;
        for (int k = 1; k <= 68; k++) begin
            tick(1);
            chk($sformatf("trace.pc[%0d]", k), dut.pc_in, trace[k]);
            if (k == 67) chk("r18_before_lw", reg_rd(18), 32'd0);
            if (k == 68) chk("r18_after_lw", reg_rd(18), 32'h37);
        end
        tick(22);
        chk("final.pc", dut.pc_in, 32'h34);
        chk("final.r16", reg_rd(16), 32'h0A);
        chk("final.r17", reg_rd(17), 32'h37);
        chk("final.r18", reg_rd(18), 32'h37);
        chk("final.mem0", mem_word(0), 32'h37);
`ifdef SEG_HEX_EN
        chk_segs("final", 7'b1111000, 7'b0110000, 7'h40, 7'h40, 7'h40);
`else
        chk_segs("final", 7'b0010010, 7'b0010010, 7'h40, 7'h40, 7'h40);
`endif

        // Forced instruction vectors
        pc_exp = 32'h34;
        for (int i = 0; i <= 16; i++) begin
            forced_instr = vecs[i].instr;
            force dut.im_instruction = forced_instr;
            tick(1);
            case (vecs[i].pc_mode)
                PBr:     pc_exp = pc_exp + 32'd4 + vecs[i].pc_arg;
                PJmp:    pc_exp = {pc_exp[31:28] + 4'd0, vecs[i].pc_arg[27:0]};
                default: pc_exp = pc_exp + 32'd4;
            endcase
            chk({vecs[i].name, ".pc"}, dut.pc_in, pc_exp);
            if (vecs[i].kind == KReg)
                chk({vecs[i].name, ".reg"}, reg_rd(vecs[i].idx), vecs[i].exp);
            else if (vecs[i].kind == KMem)
                chk({vecs[i].name, ".mem"}, mem_word(vecs[i].idx), vecs[i].exp);
        end

        // Display with multi-digit values
        forced_instr = 32'h20113039;
        force dut.im_instruction = forced_instr;
        tick(1);
        chk("disp12345.r17", reg_rd(17), 32'd12345);
`ifdef SEG_HEX_EN
        chk_segs("disp12345", 7'b0010000, 7'b0110000, 7'h40, 7'b0110000, 7'h40);
`else
        chk_segs("disp12345", 7'b0010010, 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001);
`endif
        forced_instr = 32'h2011FFFF;
        force dut.im_instruction = forced_instr;
        tick(1);
`ifdef SEG_HEX_EN
        chk_segs("disp_all1", 7'b0001110, 7'b0001110, 7'b0001110, 7'b0001110, 7'b0001110);
`else
        chk_segs("disp_all1", 7'b0010010, 7'b0010000, 7'b0100100, 7'b1111000, 7'b0000010);
`endif
        release dut.im_instruction;

        // Mid-run reset from dirty state, then rerun
        tick(30);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("midrst.pc", dut.pc_in, 32'd0);
        chk("midrst.r16", reg_rd(16), 32'd0);
        chk("midrst.r22", reg_rd(22), 32'd0);
        chk("midrst.r21", reg_rd(21), 32'd0);
        chk("midrst.mem4", mem_word(4), 32'd0);
        chk_segs("midrst", 7'h40, 7'h40, 7'h40, 7'h40, 7'h40);
        tick(67);
        chk("rerun.pc67", dut.pc_in, 32'h30);
        tick(1);
        chk("rerun.pc68", dut.pc_in, 32'h34);
        chk("rerun.r17", reg_rd(17), 32'h37);
        chk("rerun.r18", reg_rd(18), 32'h37);
        tick(5);
        chk("rerun.spin_pc", dut.pc_in, 32'h34);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mips_top.md
# mips_top

Single-cycle 32-bit MIPS-subset processor with on-chip instruction ROM, 32×32 register file and 32-byte data memory. A fixed Fibonacci program runs from reset and leaves n in $s0 (R16) and fib(n) in $s1 (R17). Five 7-segment outputs continuously show R17. This is the FPGA top level; the bench probes internals by hierarchical name.

## Interface
- No parameters.
- `clk` input 1: sole clock, rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `seg_first` output 7: digit 0, least significant.
- `seg_second` output 7: digit 1.
- `seg_third` output 7: digit 2.
- `seg_fourth` output 7: digit 3.
- `seg_fifth` output 7: digit 4, most significant.
- Segment encoding: bit0=a … bit6=g, active-low. "0"=1000000, "3"=0110000, "5"=0010010, "7"=1111000.
- Internal nets exposed for debug:
  - `pc_in`, `im_instruction`, `alu_result`, `r_read1`, `r_read2`, `r_wbdata`
  - `c_ALUOp` (2 bits), `c_ALUcontrol` (4 bits), `c_MemRead`, `c_MemWrite`
  - instances `u_Register` (array `RegData[0:31]`, 32 bits) and `u_Data_memory` (array `Dmem[0:31]`, 8 bits).

## Operation
- Supported instructions:
  - R-type: add, sub, and, or, slt.
  - I-type: addi, lw, sw, beq.
  - J-type: j.
  - All other encodings, including 0x00000000, execute as a NOP: PC+4, no writes.
- Arithmetic wraps modulo 2^32; no overflow traps.
- slt is a signed compare.
- Immediates are sign-extended.
- beq target = PC+4+(imm<<2).
- j target = {PC+4[31:28], addr26, 00}.
- Register file:
  - Two combinational read ports, one write port.
  - Writes to R0 are ignored; R0 always reads 0.
- Data memory:
  - Byte array, little-endian words.
  - Address = alu_result[4:0], word-aligned, wraps mod 32.
  - Combinational read.
- Instruction ROM: 64 words indexed by PC[7:2]. Unlisted words are 0 (NOP). Program:
  - 0x00 addi $s0,$0,10
  - 0x04 addi $t0,$0,0
  - 0x08 addi $t1,$0,1
  - 0x0C addi $t2,$0,0
  - 0x10 beq $t2,$s0,+5 (to 0x28)
  - 0x14 add $t3,$t0,$t1
  - 0x18 add $t0,$t1,$0
  - 0x1C add $t1,$t3,$0
  - 0x20 addi $t2,$t2,1
  - 0x24 j 0x10
  - 0x28 add $s1,$t0,$0
  - 0x2C sw $s1,0($0)
  - 0x30 lw $s2,0($0)
  - 0x34 j 0x34 (halt loop)
- Display: combinational from RegData[17]. Default mode shows R17 mod 100000 as five decimal digits, leading zeros shown.

## Timing
- Every instruction completes in one cycle.
- On each rising edge, in the same edge:
  - PC updates.
  - Register write-back commits.
  - Memory store commits.
- Reads and display are combinational; seg outputs change in the cycle after the R17 write edge.
- Reset:
  - While `rst`=1 at an edge: PC←0, all 32 registers←0, all 32 data bytes←0, no instruction side effects.
  - After reset, all displays read "0" (1000000).
  - Reset asserted mid-program restarts from 0x00 on the next edge after deassertion.
- lw returns the value stored by a sw in any earlier cycle.
- Program completes at 68 cycles after reset release, then spins at 0x34 with no further state change.

## Configuration
- `SEG_HEX_EN`:
  - Defined: displays show R17[19:0] as five hex digits. A–F use the usual patterns with lowercase b and d.
  - Undefined: decimal display as in Operation.
  - Core behaviour is identical in both modes.

## Test plan
- Reset 2 cycles, release, run 90 cycles:
  - R16=0x0000000A, R17=0x00000037, R18=0x00000037.
  - Data memory word 0x00 = 0x00000037.
  - PC=0x34.
- Decimal build after completion: seg_first=seg_second=0010010 ("5"); others 1000000.
- `SEG_HEX_EN` build after completion: seg_first=1111000 ("7"), seg_second=0110000 ("3"), others "0".
- Cycle-by-cycle PC trace: 0x00,04,08,0C,10, then the loop 14..24→10 ten times, then 0x28; beq not taken for $t2<10.
- Assert `rst` at cycle 30 for one cycle:
  - Registers, memory and PC clear.
  - Rerun yields the same final R17=55 at 68 cycles after release.
- Force `im_instruction` encodings with R0 as destination (e.g. addi $0,$0,5): R0 stays 0. Undefined opcode: only PC advances by 4.
